// File: rtl/present_pkg.sv
// present_pkg: shared constants, S-box tables and phase enum for the PRESENT-80 core.
// Build option: define PRESENT_DECRYPT_EN to include the decrypt datapath.
package present_pkg;

    localparam int STATE_W = 64;
    localparam int KEY_W   = 80;
    localparam int CNT_W   = 5;
    localparam int ROUNDS  = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

`ifdef PRESENT_DECRYPT_EN
    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV[x];
    endfunction
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_ROUND  = 3'd2,
        ST_FINAL  = 3'd3,
        ST_DONE   = 3'd4
    } phase_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/present_round.sv
// present_round: one combinational PRESENT round plus the matching key-schedule step.
// i_dir = 0 gives the forward round and forward key update; i_dir = 1 gives the
// inverse round invS(invP(state ^ key)) and the inverse key step (only when
// PRESENT_DECRYPT_EN is defined; otherwise the block is forward-only).
module present_round
    import present_pkg::*;
(
    input  logic               i_dir,
    input  logic [STATE_W-1:0] i_state,
    input  logic [KEY_W-1:0]   i_key,
    input  logic [CNT_W-1:0]   i_cnt,
    output logic [STATE_W-1:0] o_state,
    output logic [KEY_W-1:0]   o_key
);

    logic [STATE_W-1:0] w_mixed;

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[6'(4*n) +: 4] = sbox(x[6'(4*n) +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[6'((16*i) % 63)] = x[6'(i)];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ c;
        return r;
    endfunction

`ifdef PRESENT_DECRYPT_EN
    function automatic logic [63:0] sbox_inv_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[6'(4*n) +: 4] = sbox_inv(x[6'(4*n) +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] p_layer_inv(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[6'(i)] = x[6'((16*i) % 63)];
        end
        y[63] = x[63];
        return y;
    endfunction

    // Undo key_fwd step by step in reverse order.
    function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] c);
        logic [79:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ c;
        r[79:76]   = sbox_inv(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction
`endif

    assign w_mixed = i_state ^ i_key[79:16];

    // Select the forward or inverse round and key step.
`ifdef PRESENT_DECRYPT_EN
    always_comb begin
        o_state = p_layer(sbox_layer(w_mixed));
        o_key   = key_fwd(i_key, i_cnt);
        if (i_dir) begin
            o_state = sbox_inv_layer(p_layer_inv(w_mixed));
            o_key   = key_inv(i_key, i_cnt);
        end
    end
`else
    logic w_unused_dir;
    assign w_unused_dir = i_dir;

    always_comb begin
        o_state = p_layer(sbox_layer(w_mixed));
        o_key   = key_fwd(i_key, i_cnt);
    end
`endif

endmodule

// File: rtl/present_core.sv
// present_core: iterative PRESENT-80 block cipher, one round per clock.
// Build option: PRESENT_DECRYPT_EN adds decryption (control = 1); without it
// control is ignored and every operation encrypts.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, nothing to do
// ST_KEYEXP | decrypt only: run forward key schedule up to K32
// ST_ROUND  | one cipher round per cycle (encrypt 1..31, decrypt 31..1)
// ST_FINAL  | whitening with last key, write odat, raise done
// ST_DONE   | result held until next load or reset
//
// A load edge arms the operation directly in ST_KEYEXP/ST_ROUND; those states
// only advance on cycles with load = 0, so work starts when load falls.
module present_core
    import present_pkg::*;
#(
    parameter int NUM_ROUNDS = ROUNDS
) (
    input  logic               clk,
    input  logic               iReset_n,
    input  logic               load,
    input  logic               control,
    input  logic [STATE_W-1:0] idat,
    input  logic [KEY_W-1:0]   key,
    output logic [STATE_W-1:0] odat,
    output logic               done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS);

    phase_t             r_phase;
    logic [STATE_W-1:0] r_state;
    logic [KEY_W-1:0]   r_key;
    logic [CNT_W-1:0]   r_cnt;
    logic [STATE_W-1:0] r_odat;
    logic               r_done;

    logic               w_dir;
    logic [STATE_W-1:0] w_state_next;
    logic [KEY_W-1:0]   w_key_next;

`ifdef PRESENT_DECRYPT_EN
    logic               r_dir;
    // KEYEXP needs the forward key step even when decrypting.
    assign w_dir = r_dir && (r_phase == ST_ROUND);
`else
    logic               w_unused_control;
    assign w_unused_control = control;
    assign w_dir            = 1'b0;
`endif

    present_round u_round (
        .i_dir   (w_dir),
        .i_state (r_state),
        .i_key   (r_key),
        .i_cnt   (r_cnt),
        .o_state (w_state_next),
        .o_key   (w_key_next)
    );

    // Phase FSM with datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!iReset_n) begin
            r_phase <= ST_IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_cnt   <= '0;
            r_odat  <= '0;
            r_done  <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
            r_dir   <= 1'b0;
`endif
        end else if (load) begin
            r_state <= idat;
            r_key   <= key;
            r_cnt   <= CNT_W'(1);
            r_done  <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
            r_dir   <= control;
            r_phase <= control ? ST_KEYEXP : ST_ROUND;
`else
            r_phase <= ST_ROUND;
`endif
        end else begin
            case (r_phase)
`ifdef PRESENT_DECRYPT_EN
                ST_KEYEXP: begin
                    r_key <= w_key_next;
                    if (r_cnt == LAST_CNT) begin
                        r_phase <= ST_ROUND;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                ST_ROUND: begin
                    r_state <= w_state_next;
                    r_key   <= w_key_next;
`ifdef PRESENT_DECRYPT_EN
                    if (r_dir) begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_phase <= ST_FINAL;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end else begin
                        if (r_cnt == LAST_CNT) begin
                            r_phase <= ST_FINAL;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
`else
                    if (r_cnt == LAST_CNT) begin
                        r_phase <= ST_FINAL;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_FINAL: begin
                    r_odat  <= r_state ^ r_key[79:16];
                    r_done  <= 1'b1;
                    r_phase <= ST_DONE;
                end
                default: ;
            endcase
        end
    end

    assign odat = r_odat;
    assign done = r_done;

endmodule

// File: tb/tb_present_core.sv
// tb_present_core: directed and random checks of present_core against a
// round-key-list model of PRESENT-80.
module tb_present_core;

    logic        clk = 1'b0;
    logic        iReset_n;
    logic        load;
    logic        control;
    logic [63:0] idat;
    logic [79:0] key;
    logic [63:0] odat;
    logic        done;

    int errors = 0;
    int checks = 0;

`ifdef PRESENT_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    present_core #(.NUM_ROUNDS(31)) dut (
        .clk      (clk),
        .iReset_n (iReset_n),
        .load     (load),
        .control  (control),
        .idat     (idat),
        .key      (key),
        .odat     (odat),
        .done     (done)
    );

    // ---------------- reference model ----------------
    localparam logic [3:0] SB [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    function automatic logic [3:0] m_s(input logic [3:0] x);
        return SB[x];
    endfunction

    function automatic logic [3:0] m_sinv(input logic [3:0] x);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++) begin
            if (SB[v] == x) r = 4'(v);
        end
        return r;
    endfunction

    // Round key n (1..32): top 64 bits of the key register after n-1 updates.
    function automatic logic [63:0] m_rk(input logic [79:0] k, input int n);
        logic [79:0] r;
        r = k;
        for (int i = 1; i < n; i++) begin
            r        = (r << 61) | (r >> 19);
            r[79:76] = m_s(r[79:76]);
            r[19:15] = r[19:15] ^ 5'(i);
        end
        return r[79:16];
    endfunction

    function automatic logic [63:0] m_perm(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        int          dst;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            dst = (i == 63) ? 63 : (16 * i) % 63;
            if (!inv) y[6'(dst)] = x[6'(i)];
            else      y[6'(i)]   = x[6'(dst)];
        end
        return y;
    endfunction

    function automatic logic [63:0] m_subst(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[6'(4*n) +: 4] = inv ? m_sinv(x[6'(4*n) +: 4]) : m_s(x[6'(4*n) +: 4]);
        end
        return y;
    endfunction

    function automatic logic [63:0] m_cipher(input logic [63:0] d, input logic [79:0] k, input bit dec);
        logic [63:0] s;
        if (!dec) begin
            s = d;
            for (int r = 1; r <= 31; r++) begin
                s = m_perm(m_subst(s ^ m_rk(k, r), 1'b0), 1'b0);
            end
            s = s ^ m_rk(k, 32);
        end else begin
            s = d ^ m_rk(k, 32);
            for (int r = 31; r >= 1; r--) begin
                s = m_subst(m_perm(s, 1'b1), 1'b1) ^ m_rk(k, r);
            end
        end
        return s;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble_inputs();
        idat    = {$urandom, $urandom};
        key     = {16'($urandom), $urandom, $urandom};
        control = 1'($urandom);
    endtask

    // Called at a negedge. Holds load for 'hold' cycles (junk first, real data last).
    task automatic run_op(input logic [63:0] d, input logic [79:0] k, input logic c,
                          input logic [63:0] exp, input string tag, input int hold);
        logic [63:0] prev;
        int          lat;
        int          exp_lat;
        prev    = odat;
        exp_lat = (c && DEC_EN) ? 63 : 32;
        load    = 1'b1;
        for (int h = 1; h < hold; h++) begin
            scramble_inputs();
            @(posedge clk);
            @(negedge clk);
        end
        idat    = d;
        key     = k;
        control = c;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".done_cleared"}, 64'(done), 64'd0);
        check({tag, ".odat_kept"}, odat, prev);
        load = 1'b0;
        scramble_inputs();
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat == 5) scramble_inputs();
        end while (!done && lat < 200);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".odat"}, odat, exp);
        repeat (4) @(negedge clk);
        scramble_inputs();
        @(negedge clk);
        check({tag, ".hold_done"}, 64'(done), 64'd1);
        check({tag, ".hold_odat"}, odat, exp);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [79:0] K1 = 80'h466574656c48636d7573;
    localparam logic [79:0] K3 = 80'h00000000000000000001;

    initial begin
        logic [63:0] d;
        logic [79:0] k;
        logic        c;

        iReset_n = 1'b0;
        load     = 1'b0;
        control  = 1'b0;
        idat     = '0;
        key      = '0;
        repeat (2) @(negedge clk);
        check("reset.odat", odat, 64'd0);
        check("reset.done", 64'(done), 64'd0);
        iReset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle.done", 64'(done), 64'd0);

        check("model.ex1", m_cipher(64'h4c746e677579656e, K1, 1'b0), 64'h0e1d00d4e46ba99c);
        check("model.std_dec", m_cipher(64'h5579c1387b228445, 80'd0, 1'b1), 64'd0);

        run_op(64'h4c746e677579656e, K1, 1'b0, 64'h0e1d00d4e46ba99c, "ex1", 1);
        run_op(64'h0e1d00d4e46ba99c, K1, 1'b1,
               DEC_EN ? 64'h4c746e677579656e : m_cipher(64'h0e1d00d4e46ba99c, K1, 1'b0), "ex2", 1);
        run_op(64'h466574656c5f5553, K3, 1'b0, 64'h9346f086b0b1c9b4, "ex3", 1);
        run_op(64'h9346f086b0b1c9b4, K3, 1'b1,
               DEC_EN ? 64'h466574656c5f5553 : m_cipher(64'h9346f086b0b1c9b4, K3, 1'b0), "ex4", 1);
        run_op(64'd0, 80'd0, 1'b0, 64'h5579c1387b228445, "std_enc", 1);
        run_op(64'h5579c1387b228445, 80'd0, 1'b1,
               DEC_EN ? 64'd0 : m_cipher(64'h5579c1387b228445, 80'd0, 1'b0), "std_dec", 1);

        // Load held for several cycles: only the last sample counts.
        run_op(64'h4c746e677579656e, K1, 1'b0, 64'h0e1d00d4e46ba99c, "held_load", 3);

        // Random operations, random direction and load length.
        for (int n = 0; n < 6; n++) begin
            d = {$urandom, $urandom};
            k = {16'($urandom), $urandom, $urandom};
            c = 1'($urandom);
            run_op(d, k, c, m_cipher(d, k, c && DEC_EN), "random", 1 + int'($urandom_range(0, 1)));
        end

        // Abort mid-operation with a fresh load.
        load = 1'b1; idat = 64'h0123456789abcdef; key = K3; control = 1'b1;
        @(posedge clk); @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);
        check("abort.no_done", 64'(done), 64'd0);
        run_op(64'h466574656c5f5553, K3, 1'b0, 64'h9346f086b0b1c9b4, "abort.new", 1);

        // Reset at cycle 10 of an encrypt.
        load = 1'b1; idat = 64'h4c746e677579656e; key = K1; control = 1'b0;
        @(posedge clk); @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        iReset_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_mid.odat", odat, 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        iReset_n = 1'b1;
        repeat (70) @(negedge clk);
        check("rst_mid.no_partial_done", 64'(done), 64'd0);
        check("rst_mid.no_partial_odat", odat, 64'd0);

        // Operation after reset still works.
        run_op(64'd0, 80'd0, 1'b0, 64'h5579c1387b228445, "post_rst", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
